// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int PC_STEP  = 4;
  localparam int RESET_PC = 0;
  localparam int STALL_W  = 32;

endpackage

// File: rtl/fetch_ctrl_adder.sv
// Plain W-bit modulo adder; carry out is deliberately dropped so PC wraps.
module fetch_ctrl_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: one outstanding instruction-memory request, a single
// holding register toward decode, and redirect handling with stale-response drain.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int N = 64,
  parameter int I = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_F,
  input  logic [N-1:0]       PCBranch_F,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ack,
  input  logic [I-1:0]       imem_rdata,
  output logic               instr_valid_F,
  input  logic               instr_ready_D,
  output logic [I-1:0]       instr_F,
  output logic [N-1:0]       pc_F,
  output logic [STALL_W-1:0] stall_cnt
);

  state_t       state, state_nx;
  logic [N-1:0] pc, pc_nx, pc_inc;
  logic         latch;
  logic         stall_inc;

  fetch_ctrl_adder #(.W(N)) u_inc (
    .a   (pc),
    .b   (N'(PC_STEP)),
    .sum (pc_inc)
  );

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    latch    = 1'b0;
    case (state)
      ST_REQ: begin
        // The request issued this cycle stays in flight even on redirect.
        if (PCSrc_F) begin
          pc_nx    = PCBranch_F;
          state_nx = ST_DRAIN;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (PCSrc_F) begin
          pc_nx    = PCBranch_F;
          state_nx = imem_ack ? ST_REQ : ST_DRAIN;
        end else if (imem_ack) begin
          latch    = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Redirect wins over the sequential step even when decode accepts.
        if (PCSrc_F) begin
          pc_nx    = PCBranch_F;
          state_nx = ST_REQ;
        end else if (instr_ready_D) begin
          pc_nx    = pc_inc;
          state_nx = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (PCSrc_F)  pc_nx    = PCBranch_F;
        if (imem_ack) state_nx = ST_REQ;
      end
      default: state_nx = ST_REQ;
    endcase
  end

  assign imem_req      = (state == ST_REQ)  && !reset;
  assign instr_valid_F = (state == ST_HOLD) && !reset;
  assign imem_addr     = pc;
  assign stall_inc     = ((state == ST_WAIT) || (state == ST_DRAIN)) && !imem_ack &&
                         (stall_cnt != '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_REQ;
      pc        <= N'(RESET_PC);
      instr_F   <= '0;
      pc_F      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (latch) begin
        instr_F <= imem_rdata;
        pc_F    <= pc;
      end
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl against a transaction-level model.
module tb_fetch_ctrl;

  localparam int N = 64;
  localparam int I = 32;

  logic          clk;
  logic          reset;
  logic          PCSrc_F;
  logic [N-1:0]  PCBranch_F;
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_ack;
  logic [I-1:0]  imem_rdata;
  logic          instr_valid_F;
  logic          instr_ready_D;
  logic [I-1:0]  instr_F;
  logic [N-1:0]  pc_F;
  logic [31:0]   stall_cnt;

  fetch_ctrl #(.N(N), .I(I)) dut (
    .clk           (clk),
    .reset         (reset),
    .PCSrc_F       (PCSrc_F),
    .PCBranch_F    (PCBranch_F),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid_F (instr_valid_F),
    .instr_ready_D (instr_ready_D),
    .instr_F       (instr_F),
    .pc_F          (pc_F),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: is a fetch in flight, will its data be thrown
  // away, is an instruction parked for decode.
  bit           started = 0;
  bit           m_out, m_stale, m_hold;
  logic [N-1:0] m_pc, m_pcf;
  logic [I-1:0] m_instr;
  logic [31:0]  m_stall;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = '0; m_out = 0; m_stale = 0; m_hold = 0;
      m_instr = '0; m_pcf = '0; m_stall = '0; started = 1;
    end else if (!m_out && !m_hold) begin
      m_out   = 1;
      m_stale = PCSrc_F;
      if (PCSrc_F) m_pc = PCBranch_F;
    end else if (m_out) begin
      if (!imem_ack) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (PCSrc_F) m_stale = 1;
      end else begin
        m_out = 0;
        if (!m_stale && !PCSrc_F) begin
          m_hold = 1; m_instr = imem_rdata; m_pcf = m_pc;
        end
        m_stale = 0;
      end
      if (PCSrc_F) m_pc = PCBranch_F;
    end else begin
      if (PCSrc_F) begin
        m_pc = PCBranch_F; m_hold = 0;
      end else if (instr_ready_D) begin
        m_pc = m_pc + 4; m_hold = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("imem_req",      imem_req,      !reset && !m_out && !m_hold);
      chk("imem_addr",     imem_addr,     m_pc);
      chk("instr_valid_F", instr_valid_F, !reset && m_hold);
      chk("instr_F",       instr_F,       m_instr);
      chk("pc_F",          pc_F,          m_pcf);
      chk("stall_cnt",     stall_cnt,     m_stall);
    end
  end

  // Stimulus knobs and memory responder state.
  int           cyc = 0, ack_cyc = 0, mem_cnt = 0, xfers = 0;
  int           dmin = 1, dmax = 1, p_ready = 100, p_redir = 0;
  bit           spur = 0, inj_ack = 0, force_br = 0;
  logic [N-1:0] force_tgt;
  logic [I-1:0] last_rdata;

  function automatic logic [N-1:0] rnd_tgt();
    logic [N-1:0] t;
    if ($urandom_range(3, 0) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(3, 0));
    else                           t = {$urandom, $urandom} & ~64'h3;
    return t;
  endfunction

  task automatic tick(input bit rst = 1'b0);
    @(negedge clk); #1;
    cyc++;
    reset    = rst;
    imem_ack = 1'b0;
    if (rst) mem_cnt = 0;
    else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_ack = 1'b1; last_rdata = $urandom; imem_rdata = last_rdata; ack_cyc = cyc;
      end
    end else if (spur && m_hold && $urandom_range(7, 0) == 0) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
    end
    if (inj_ack) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; inj_ack = 0;
    end
    instr_ready_D = ($urandom_range(99, 0) < p_ready);
    if (force_br) begin
      PCSrc_F = 1'b1; PCBranch_F = force_tgt; force_br = 0;
    end else begin
      PCSrc_F = ($urandom_range(99, 0) < p_redir); PCBranch_F = rnd_tgt();
    end
    #1;
    if (instr_valid_F && instr_ready_D) xfers++;
    if (imem_req) mem_cnt = $urandom_range(dmax, dmin);
  endtask

  task automatic wait_req(output logic [N-1:0] a);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (imem_req) begin a = imem_addr; return; end
    end
    chk("req_timeout", 0, 1);
    a = '0;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (instr_valid_F) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  logic [N-1:0] a;
  int           c0, c1, s0, x0, vcnt;

  initial begin
    reset = 1'b1; PCSrc_F = 0; PCBranch_F = '0; imem_ack = 0; imem_rdata = '0; instr_ready_D = 0;
    tick(1); tick(1);
    chk("rst_req",   imem_req, 0);
    chk("rst_valid", instr_valid_F, 0);
    chk("rst_stall", stall_cnt, 0);

    // 1-cycle memory, decode always ready
    wait_req(a); c0 = cyc; chk("s1_addr0", a, 64'h0);
    wait_req(a); c1 = cyc; chk("s1_addr1", a, 64'h4); chk("s1_gap1", c1 - c0, 3);
    wait_req(a); chk("s1_addr2", a, 64'h8); chk("s1_gap2", cyc - c1, 3);
    chk("s1_stall", stall_cnt, 0);

    // slow response at 0x10
    wait_req(a); chk("s2_addr_c", a, 64'hC);
    dmin = 4; dmax = 4;
    wait_req(a); chk("s2_addr", a, 64'h10); s0 = stall_cnt;
    wait_valid();
    chk("s2_lat",   cyc - ack_cyc, 1);
    chk("s2_stall", stall_cnt, s0 + 3);
    chk("s2_pcf",   pc_F, 64'h10);
    chk("s2_instr", instr_F, last_rdata);

    // redirect in WAIT, stale data returns two cycles later
    dmin = 3; dmax = 3;
    wait_req(a); chk("s3_addr14", a, 64'h14);
    force_br = 1; force_tgt = 64'h100;
    vcnt = 0;
    for (int k = 0; k < 20 && !(k > 0 && imem_req); k++) begin
      tick();
      if (instr_valid_F) vcnt++;
    end
    chk("s3_novalid", vcnt, 0);
    chk("s3_req",  imem_req, 1);
    chk("s3_addr", imem_addr, 64'h100);

    // decode back-pressure
    p_ready = 0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("s4_valid", instr_valid_F, 1);
      chk("s4_noreq", imem_req, 0);
      chk("s4_pcf",   pc_F, 64'h100);
      chk("s4_instr", instr_F, last_rdata);
    end
    p_ready = 100; dmin = 1; dmax = 1;
    wait_req(a); chk("s4_next", a, 64'h104);

    // accept and redirect in the same cycle
    p_ready = 0;
    wait_valid();
    x0 = xfers; p_ready = 100; force_br = 1; force_tgt = 64'h200;
    wait_req(a);
    chk("s5_addr",  a, 64'h200);
    chk("s5_xfers", xfers - x0, 1);

    // wrap at the top of the address space
    p_ready = 0;
    wait_valid();
    p_ready = 100; force_br = 1; force_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
    wait_req(a); chk("s6_top",  a, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_req(a); chk("s6_wrap", a, 64'h0);

    // reset while a request is outstanding
    dmin = 6; dmax = 6;
    wait_req(a);
    tick();
    tick(1);
    chk("s6_rst_req", imem_req, 0);
    tick(1);
    chk("s6_rst_req2",   imem_req, 0);
    chk("s6_rst_valid",  instr_valid_F, 0);
    chk("s6_rst_addr",   imem_addr, 0);
    chk("s6_rst_instr",  instr_F, 0);
    chk("s6_rst_pcf",    pc_F, 0);
    chk("s6_rst_stall",  stall_cnt, 0);
    dmin = 1; dmax = 1; inj_ack = 1;
    tick();
    chk("s6_first_req",  imem_req, 1);
    chk("s6_first_addr", imem_addr, 0);
    tick();
    chk("s6_ack_ignored", instr_valid_F, 0);

    // random traffic
    dmin = 1; dmax = 5; p_ready = 70; p_redir = 10; spur = 1;
    for (int k = 0; k < 4000; k++) tick($urandom_range(299, 0) == 0);
    tick(1); tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
